wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: DATA_W, default 32, register and datapath width.
REQ-002 Parameter: REG_N, default 32, number of architectural registers; address width is 5 bits.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: memReadDataWB  input  DATA_W  load data arriving from the MEM/WB pipeline register.
REQ-006 Port: ALUResultWB  input  DATA_W  ALU result arriving from the MEM/WB pipeline register.
REQ-007 Port: registerWB  input  5  destination register number.
REQ-008 Port: memRegWB  input  1  write-data select: 1 selects memReadDataWB, 0 selects ALUResultWB.
REQ-009 Port: regWriteWB  input  1  write enable.
REQ-010 Port: readReg1 / readReg2  input  5 each  ID-stage read addresses.
REQ-011 Port: readData1 / readData2  output  DATA_W each  ID-stage read data.
REQ-012 Port: writeDataWB  output  DATA_W  selected writeback value, exported for the forwarding unit.
REQ-013 Port: writeCount  output  32  number of committed register writes since reset.

Function
REQ-014 writeDataWB SHALL be a combinational function of its inputs: memRegWB ? memReadDataWB : ALUResultWB.
REQ-015 Register write rule: on a rising clk edge with regWriteWB=1 and registerWB!=0, register[registerWB] SHALL take writeDataWB.
REQ-016 Register 0 SHALL always read as 0; writes to register 0 SHALL be discarded and SHALL NOT increment writeCount.
REQ-017 writeCount SHALL increment by 1 exactly on each write committed under REQ-015.
REQ-018 writeCount SHALL wrap from 0xFFFFFFFF to 0 with no flag.
REQ-019 Read ports SHALL be combinational and independent; both ports addressing the same register SHALL return identical data.
REQ-020 A read of a register not being written in the current cycle SHALL return its stored value with zero latency.
REQ-021 Same-cycle read of the register being written SHALL follow REQ-025/REQ-026.
REQ-022 X or Z on regWriteWB is a caller error; the bench SHALL flag it, and no behaviour is specified for it.

Reset
REQ-023 When reset is asserted, all registers and writeCount SHALL clear to 0 immediately, independent of clk.
REQ-024 While reset is high, writes SHALL be ignored and readData1/readData2 SHALL read 0; writeDataWB SHALL stay combinational. Deasserting reset mid-cycle SHALL NOT cause a write until the next rising edge.

Configuration
REQ-025 With WB_REGFILE_BYPASS_EN defined: if regWriteWB=1, registerWB!=0 and readRegN==registerWB, readDataN SHALL equal writeDataWB in the same cycle.
REQ-026 Without WB_REGFILE_BYPASS_EN: readDataN SHALL return the pre-write stored value in that cycle and the new value from the cycle after the edge. The hazard unit SHALL then account for one extra stall cycle.

Structure
REQ-027 A shared package SHALL hold DATA_W, the register-address width (5), and the REG_ZERO constant (0).
REQ-028 One sub-module, wb_regfile_rdport (a single read port with zero-register masking and the optional bypass), SHALL be instantiated twice.
REQ-029 Storage SHALL be a flop array written from one always block; there SHALL be no other state besides writeCount.

Verification
REQ-030 Reset: preload r5=0x1234, assert reset between clock edges -> readData1 with readReg1=5 is 0 at once, and writeCount=0.
REQ-031 Select: memRegWB=1, memReadDataWB=0xDEADBEEF, ALUResultWB=0x11, registerWB=8, regWriteWB=1, then one edge -> r8=0xDEADBEEF, writeCount=1. Repeat with memRegWB=0 -> r8=0x11, writeCount=2.
REQ-032 Zero register: write 0xFFFFFFFF to r0 -> readData2 with readReg2=0 is 0, and writeCount is unchanged.
REQ-033 Bypass: r3=0xA, write 0xB to r3 with readReg1=readReg2=3 before the edge -> reads 0xB with WB_REGFILE_BYPASS_EN defined, 0xA without it, and 0xB after the edge in both builds.
REQ-034 Wrap: force writeCount to 0xFFFFFFFF, then do one valid write -> writeCount=0.
REQ-035 Disabled write: regWriteWB=0 with registerWB=4 and data 0x55 -> r4 is unchanged and writeCount is unchanged.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: constants shared by the writeback register file.
//   DATA_W   - default register/datapath width
//   ADDR_W   - register-number width (fixed at 5 bits)
//   REG_ZERO - architectural zero register number
// Optional feature macro used by the register file: WB_REGFILE_BYPASS_EN.
package wb_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: groups the writeback and ID-stage read signals of wb_regfile.
//   master modport - pipeline side: drives writeback data/control and read addresses
//   slave modport  - register file side: returns read data, writeDataWB, writeCount
interface wb_regfile_if #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W
);
  import wb_regfile_pkg::*;

  logic [DATA_W-1:0] memReadDataWB;
  logic [DATA_W-1:0] ALUResultWB;
  logic [ADDR_W-1:0] registerWB;
  logic              memRegWB;
  logic              regWriteWB;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] writeDataWB;
  logic [31:0]       writeCount;

  modport master (
    output memReadDataWB, ALUResultWB, registerWB, memRegWB, regWriteWB,
    output readReg1, readReg2,
    input  readData1, readData2, writeDataWB, writeCount
  );

  modport slave (
    input  memReadDataWB, ALUResultWB, registerWB, memRegWB, regWriteWB,
    input  readReg1, readReg2,
    output readData1, readData2, writeDataWB, writeCount
  );

endinterface : wb_regfile_if

// File: rtl/wb_regfile_rdport.sv
// wb_regfile_rdport: one combinational read port of the register file.
//   reset_i    - register file reset; forces the read data to zero
//   rd_addr_i  - register number to read
//   regs_i     - current contents of the storage array
//   wr_en_i    - a write is being committed this cycle (already excludes r0)
//   wr_addr_i  - register number being written
//   wr_data_i  - value being written
//   rd_data_o  - read data
// With WB_REGFILE_BYPASS_EN defined, a read of the register being written
// returns the value being written in the same cycle; otherwise it returns
// the stored (pre-write) value.
module wb_regfile_rdport
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int REG_N  = 32
) (
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] regs_i [REG_N],
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

`ifndef WB_REGFILE_BYPASS_EN
  // Write-side inputs only matter when bypass is built in.
  logic unused_bypass_s;
  assign unused_bypass_s = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

  // Read mux: zero during reset, for r0 and for unimplemented registers.
  always_comb begin
    rd_data_o = '0;
    if (reset_i || (rd_addr_i == REG_ZERO) || (int'(rd_addr_i) >= REG_N)) begin
      rd_data_o = '0;
    end
`ifdef WB_REGFILE_BYPASS_EN
    else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end
`endif
    else begin
      rd_data_o = regs_i[rd_addr_i];
    end
  end

endmodule : wb_regfile_rdport

// File: rtl/wb_regfile.sv
// wb_regfile: pipeline writeback stage plus two-read/one-write register file.
//   clk   - single clock, all state updates on the rising edge
//   reset - asynchronous active-high reset; clears registers and writeCount
//   bus   - wb_regfile_if.slave: writeback data/select/enable, two read
//           ports, exported writeDataWB and committed-write counter
// Optional feature macro: WB_REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
module wb_regfile #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int REG_N  = 32
) (
  input  logic          clk,
  input  logic          reset,
  wb_regfile_if.slave   bus
);
  import wb_regfile_pkg::*;

  logic [DATA_W-1:0] reg_q [REG_N];
  logic [31:0]       write_count_q;
  logic [31:0]       write_count_d;
  logic [DATA_W-1:0] write_data_s;
  logic              write_en_s;

  assign write_data_s    = bus.memRegWB ? bus.memReadDataWB : bus.ALUResultWB;
  assign bus.writeDataWB = write_data_s;

  // A write commits only to a real, non-zero register.
  assign write_en_s = bus.regWriteWB && (bus.registerWB != REG_ZERO) &&
                      (int'(bus.registerWB) < REG_N);

  // Counter wraps naturally at 32 bits.
  always_comb begin
    write_count_d = write_count_q;
    if (write_en_s) begin
      write_count_d = write_count_q + 32'd1;
    end else begin
      write_count_d = write_count_q;
    end
  end

  // Storage array and commit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        reg_q[i] <= '0;
      end
      write_count_q <= 32'd0;
    end else begin
      if (write_en_s) begin
        reg_q[bus.registerWB] <= write_data_s;
      end
      write_count_q <= write_count_d;
    end
  end

  assign bus.writeCount = write_count_q;

  wb_regfile_rdport #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rdport1 (
    .reset_i   (reset),
    .rd_addr_i (bus.readReg1),
    .regs_i    (reg_q),
    .wr_en_i   (write_en_s),
    .wr_addr_i (bus.registerWB),
    .wr_data_i (write_data_s),
    .rd_data_o (bus.readData1)
  );

  wb_regfile_rdport #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rdport2 (
    .reset_i   (reset),
    .rd_addr_i (bus.readReg2),
    .regs_i    (reg_q),
    .wr_en_i   (write_en_s),
    .wr_addr_i (bus.registerWB),
    .wr_data_i (write_data_s),
    .rd_data_o (bus.readData2)
  );

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed, table-driven bench for wb_regfile, plus hand
// sequences for reset, bypass timing and counter wrap.
module tb_wb_regfile;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  wb_regfile_if #(.DATA_W(32)) bus ();

  wb_regfile #(.DATA_W(32), .REG_N(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        memreg;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ewd;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic memreg, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] wreg,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.regWriteWB    = we;
    bus.memRegWB      = memreg;
    bus.memReadDataWB = mem;
    bus.ALUResultWB   = alu;
    bus.registerWB    = wreg;
    bus.readReg1      = r1;
    bus.readReg2      = r2;
  endtask

  // An unknown write enable is a caller error.
  always @(negedge clk) begin
    if (!reset && $isunknown(bus.regWriteWB)) begin
      bad++;
      $display("FAIL regWriteWB_unknown actual=%b required=0/1", bus.regWriteWB);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    //           name        we    mr    mem           alu           wreg   r1     r2     e1            e2            ewd           ecnt
    vecs[0] = '{"sel_mem",   1'b1, 1'b1, 32'hDEADBEEF, 32'h00000011, 5'd8,  5'd8,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'd1};
    vecs[1] = '{"sel_alu",   1'b1, 1'b0, 32'hDEADBEEF, 32'h00000011, 5'd8,  5'd8,  5'd0,  32'h00000011, 32'h0,        32'h00000011, 32'd2};
    vecs[2] = '{"zero_reg",  1'b1, 1'b0, 32'h0,        32'hFFFFFFFF, 5'd0,  5'd8,  5'd0,  32'h00000011, 32'h0,        32'hFFFFFFFF, 32'd2};
    vecs[3] = '{"wr_r4",     1'b1, 1'b1, 32'h00000077, 32'h0,        5'd4,  5'd4,  5'd8,  32'h00000077, 32'h00000011, 32'h00000077, 32'd3};
    vecs[4] = '{"wr_off",    1'b0, 1'b0, 32'h0,        32'h00000055, 5'd4,  5'd4,  5'd4,  32'h00000077, 32'h00000077, 32'h00000055, 32'd3};
    vecs[5] = '{"wr_r31",    1'b1, 1'b0, 32'h0,        32'hCAFE0001, 5'd31, 5'd31, 5'd4,  32'hCAFE0001, 32'h00000077, 32'hCAFE0001, 32'd4};
    vecs[6] = '{"wr_r3",     1'b1, 1'b0, 32'h0,        32'h0000000A, 5'd3,  5'd3,  5'd31, 32'h0000000A, 32'hCAFE0001, 32'h0000000A, 32'd5};

    // Reset state.
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd31);
    #1;
    chk("rst_count", bus.writeCount, 32'd0);
    chk("rst_rd1", bus.readData1, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors: drive between edges, check just after the edge.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].memreg, vecs[i].mem, vecs[i].alu,
            vecs[i].wreg, vecs[i].r1, vecs[i].r2);
      #1;
      chk({vecs[i].name, "_wd"}, bus.writeDataWB, vecs[i].ewd);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_rd1"}, bus.readData1, vecs[i].e1);
      chk({vecs[i].name, "_rd2"}, bus.readData2, vecs[i].e2);
      chk({vecs[i].name, "_cnt"}, bus.writeCount, vecs[i].ecnt);
    end

    // Same-cycle read of a register being written (r3 holds 0xA).
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h0000000B, 5'd3, 5'd3, 5'd3);
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    chk("byp_pre_rd1", bus.readData1, 32'h0000000B);
    chk("byp_pre_rd2", bus.readData2, 32'h0000000B);
`else
    chk("byp_pre_rd1", bus.readData1, 32'h0000000A);
    chk("byp_pre_rd2", bus.readData2, 32'h0000000A);
`endif
    @(posedge clk);
    #1;
    chk("byp_post_rd1", bus.readData1, 32'h0000000B);
    chk("byp_post_rd2", bus.readData2, 32'h0000000B);
    chk("byp_post_cnt", bus.writeCount, 32'd6);

    // Counter wrap: preset to all ones, then one valid write.
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
    force dut.write_count_q = 32'hFFFFFFFF;
    #1;
    release dut.write_count_q;
    #1;
    chk("wrap_preset", bus.writeCount, 32'hFFFFFFFF);
    drive(1'b1, 1'b0, 32'h0, 32'h00000001, 5'd9, 5'd9, 5'd0);
    @(posedge clk);
    #1;
    chk("wrap_cnt", bus.writeCount, 32'd0);
    chk("wrap_r9", bus.readData1, 32'h00000001);

    // Asynchronous reset between edges with r5 preloaded.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h00001234, 5'd5, 5'd5, 5'd0);
    @(posedge clk);
    #1;
    chk("pre_r5", bus.readData1, 32'h00001234);
    chk("pre_cnt", bus.writeCount, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rd1", bus.readData1, 32'd0);
    chk("arst_rd2", bus.readData2, 32'd0);
    chk("arst_cnt", bus.writeCount, 32'd0);

    // Writes ignored while reset is high; reads stay zero even for the written reg.
    drive(1'b1, 1'b0, 32'h0, 32'h00000066, 5'd6, 5'd6, 5'd5);
    #1;
    chk("rsthi_rd1", bus.readData1, 32'd0);
    chk("rsthi_wd", bus.writeDataWB, 32'h00000066);
    @(posedge clk);
    #1;
    chk("rsthi_cnt", bus.writeCount, 32'd0);
    chk("rsthi_rd1_post", bus.readData1, 32'd0);

    // Release reset mid-cycle: no write until the next rising edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_cnt", bus.writeCount, 32'd0);
`ifdef WB_REGFILE_BYPASS_EN
    chk("rel_rd1", bus.readData1, 32'h00000066);
`else
    chk("rel_rd1", bus.readData1, 32'd0);
`endif
    chk("rel_rd2", bus.readData2, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_post_cnt", bus.writeCount, 32'd1);
    chk("rel_post_rd1", bus.readData1, 32'h00000066);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_regfile
